memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access_if.sv | 22 ++
 rtl/memory_access.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_if.sv
// Data-memory request/response bus between the memory-access stage and the data memory.
// The stage drives the request channel; the memory returns ready and read data.
interface memory_access_if;
  logic        dmem_valid;
  logic        dmem_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    input  dmem_ready, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
    output dmem_ready, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/memory_access.sv
// RV32I memory-access stage: passes ALU results to writeback and runs loads/stores
// over a valid/ready data bus with alignment checks and an outstanding-access timeout.
module memory_access #(
  parameter int MEM_TIMEOUT = 255
) (
  input  logic        req,
  input  logic        reset,
  input  logic        stall_in,
  input  logic        valid_in,
  input  logic [6:0]  opcode_in,
  input  logic [2:0]  funct3_in,
  input  logic [31:0] result_in,
  input  logic [31:0] rs2_value_in,
  input  logic [4:0]  rd_in,
  output logic        stall_out,
  output logic        rd_write,
  output logic [4:0]  rd_out,
  output logic [31:0] result_out,
  output logic        misaligned_out,
  output logic        bus_error_out,
  memory_access_if.master dmem
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam int            CW   = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CW-1:0] LAST = CW'(MEM_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RESP} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          we_q, we_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wstrb_q, wstrb_d;
  logic [2:0]    f3_q, f3_d;
  logic [1:0]    off_q, off_d;
  logic [4:0]    ld_rd_q, ld_rd_d;
  logic          rd_write_q, rd_write_d;
  logic [4:0]    rd_out_q, rd_out_d;
  logic [31:0]   result_q, result_d;
  logic          mis_q, mis_d;
  logic          berr_q, berr_d;

  logic        is_load, is_store, misaligned;
  logic [31:0] shifted, load_data;

  assign is_load    = (opcode_in == OP_LOAD);
  assign is_store   = (opcode_in == OP_STORE);
  assign misaligned = (funct3_in[1:0] == 2'b01 && result_in[0]) ||
                      (funct3_in[1]   == 1'b1  && result_in[1:0] != 2'b00);

  // Byte lane selection: bring the addressed byte/halfword down to bit 0.
  assign shifted = dmem.dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    unique case (f3_q)
      3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
      3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
      3'b100:  load_data = {24'h0, shifted[7:0]};
      3'b101:  load_data = {16'h0, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d    = state_q;
    cnt_d      = cnt_q;
    valid_d    = valid_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    f3_d       = f3_q;
    off_d      = off_q;
    ld_rd_d    = ld_rd_q;
    rd_write_d = 1'b0;
    rd_out_d   = rd_out_q;
    result_d   = result_q;
    mis_d      = 1'b0;
    berr_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (valid_in && !stall_in) begin
          if (is_load || is_store) begin
            if (misaligned) begin
              mis_d = 1'b1;
            end else begin
              state_d = REQ;
              cnt_d   = '0;
              valid_d = 1'b1;
              we_d    = is_store;
              addr_d  = {result_in[31:2], 2'b00};
              f3_d    = funct3_in;
              off_d   = result_in[1:0];
              ld_rd_d = rd_in;
              wdata_d = 32'h0;
              wstrb_d = 4'b0000;
              if (is_store) begin
                unique case (funct3_in[1:0])
                  2'b00: begin
                    wdata_d = {4{rs2_value_in[7:0]}};
                    wstrb_d = 4'b0001 << result_in[1:0];
                  end
                  2'b01: begin
                    wdata_d = {2{rs2_value_in[15:0]}};
                    wstrb_d = 4'b0011 << result_in[1:0];
                  end
                  default: begin
                    wdata_d = rs2_value_in;
                    wstrb_d = 4'b1111;
                  end
                endcase
              end
            end
          end else begin
            rd_write_d = (rd_in != 5'd0) && (opcode_in != OP_BRANCH);
            rd_out_d   = rd_in;
            result_d   = result_in;
          end
        end
      end

      REQ: begin
        // A handshake in the final cycle still completes; the timeout only fires without one.
        if (dmem.dmem_ready) begin
          valid_d = 1'b0;
          state_d = we_q ? IDLE : WAIT_RESP;
          cnt_d   = cnt_q + CW'(1);
        end else if (cnt_q >= LAST) begin
          valid_d = 1'b0;
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      WAIT_RESP: begin
        if (dmem.dmem_rvalid) begin
          rd_write_d = (ld_rd_q != 5'd0);
          rd_out_d   = ld_rd_q;
          result_d   = load_data;
          state_d    = IDLE;
        end else if (cnt_q >= LAST) begin
          berr_d  = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge req or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      valid_q    <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'b0000;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      ld_rd_q    <= 5'd0;
      rd_write_q <= 1'b0;
      rd_out_q   <= 5'd0;
      result_q   <= 32'h0;
      mis_q      <= 1'b0;
      berr_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      valid_q    <= valid_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      ld_rd_q    <= ld_rd_d;
      rd_write_q <= rd_write_d;
      rd_out_q   <= rd_out_d;
      result_q   <= result_d;
      mis_q      <= mis_d;
      berr_q     <= berr_d;
    end
  end

  assign stall_out       = (state_q != IDLE);
  assign rd_write        = rd_write_q;
  assign rd_out          = rd_out_q;
  assign result_out      = result_q;
  assign misaligned_out  = mis_q;
  assign bus_error_out   = berr_q;
  assign dmem.dmem_valid = valid_q;
  assign dmem.dmem_we    = we_q;
  assign dmem.dmem_addr  = addr_q;
  assign dmem.dmem_wdata = wdata_q;
  assign dmem.dmem_wstrb = wstrb_q;

endmodule
